// File: rtl/credential_lock_ctrl_pkg.sv
// Shared types and constants for the credential lock controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package credential_lock_ctrl_pkg;

    // ALU opcode field width and the opcodes this block may issue
    localparam int OP_W = 4;
    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_INC = 4'd13;

    // ALU status vector layout
    localparam int STATUS_W = 5;
    localparam int ZERO_BIT = 4;

    // Failure counter width; holds MAX_TRIES up to 15
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_GRANT = 3'd4,
        ST_FAIL  = 3'd5,
        ST_LOCK  = 3'd6
    } state_t;

    // Increment that sticks at lim instead of running past it
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/credential_lock_ctrl_if.sv
// Bus bundle between the lock controller, its user and its external ALU.
// Latency: n/a (wires only).
// Backpressure: none; iStart is a single-cycle request sampled only when idle.
interface credential_lock_ctrl_if
    import credential_lock_ctrl_pkg::*;
#(
    parameter int DATA_W = 4
);
    // requests and ALU feedback
    logic                iStart;
    logic [DATA_W-1:0]   ubInputData;
    logic [DATA_W-1:0]   ubCredential;
    logic [STATUS_W-1:0] status;
    logic [DATA_W-1:0]   R;

    // ALU operands and controller status
    logic [DATA_W-1:0]   oA_T;
    logic [DATA_W-1:0]   oB_T;
    logic [OP_W-1:0]     oOp_T;
    logic [CNT_W-1:0]    ubCont;
    logic                vfnLED_On;
    logic                oLocked;
    logic                oBusy;
    logic                oDone;

    // user/ALU side
    modport master (
        output iStart, ubInputData, ubCredential, status, R,
        input  oA_T, oB_T, oOp_T, ubCont, vfnLED_On, oLocked, oBusy, oDone
    );

    // controller side
    modport slave (
        input  iStart, ubInputData, ubCredential, status, R,
        output oA_T, oB_T, oOp_T, ubCont, vfnLED_On, oLocked, oBusy, oDone
    );

endinterface

// File: rtl/credential_lock_ctrl_lock_timer.sv
// Lockout countdown: load sets LOCK_CYCLES-1, enable counts down to 0 and stops.
// Latency: expired reflects the count combinationally; load takes effect next edge.
// Backpressure: none.
module lock_timer #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);
    // LOCK_CYCLES-1 is the largest value held, so clog2(LOCK_CYCLES) bits suffice
    localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(LOCK_CYCLES - 1);

    logic [TW-1:0] cnt;

    // Load on lock entry, then count down and hold at zero rather than wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/credential_lock_ctrl.sv
// Credential check: compares entered code to stored code via an external ALU, locks out after repeated failures.
// Latency: oDone pulses 4 cycles after an accepted iStart (ISSUE, WAIT, EVAL, GRANT/FAIL).
// Backpressure: iStart is accepted only in IDLE; pulses while busy or locked are dropped.
module credential_lock_ctrl
    import credential_lock_ctrl_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input logic                   clk,
    input logic                   rst,
    credential_lock_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIES);

    state_t state;
    state_t next_state;

    // control strobes from the output decoder
    logic load_ops;
    logic set_grant;
    logic inc_cont;
    logic clr_cont;
    logic clr_all;
    logic timer_load;
    logic timer_en;
    logic lock_clr;
    logic busy;
    logic done;
    logic timer_expired;

    // registered outputs
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic [CNT_W-1:0]  cont_q;
    logic              led_q;
    logic              locked_q;

    logic zero_flag;
    assign zero_flag = bus.status[ZERO_BIT];

    // The result word and the other flags are not part of the decision
    logic unused_alu;
    assign unused_alu = ^{bus.R, bus.status[3:0]};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; any unknown encoding falls back to IDLE
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:  next_state = (bus.iStart && !locked_q) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT:  next_state = ST_EVAL;
            ST_EVAL:  next_state = zero_flag ? ST_GRANT : ST_FAIL;
            ST_GRANT: next_state = ST_IDLE;
            ST_FAIL:  next_state = (cont_q == MAX_CNT) ? ST_LOCK : ST_IDLE;
            ST_LOCK:  next_state = timer_expired ? ST_IDLE : ST_LOCK;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output decode: Moore busy/done plus strobes that update the registered outputs
    always_comb begin
        load_ops   = 1'b0;
        set_grant  = 1'b0;
        inc_cont   = 1'b0;
        clr_cont   = 1'b0;
        clr_all    = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        lock_clr   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                // operands are captured on the accepting edge so they are visible throughout ISSUE
                load_ops = bus.iStart && !locked_q;
            end
            ST_ISSUE, ST_WAIT: begin
                busy = 1'b1;
            end
            ST_EVAL: begin
                busy      = 1'b1;
                set_grant = zero_flag;
                inc_cont  = !zero_flag;
            end
            ST_GRANT: begin
                busy = 1'b1;
                done = 1'b1;
            end
            ST_FAIL: begin
                busy       = 1'b1;
                done       = 1'b1;
                timer_load = (cont_q == MAX_CNT);
            end
            ST_LOCK: begin
                busy     = 1'b1;
                timer_en = 1'b1;
                clr_cont = timer_expired;
                lock_clr = timer_expired;
            end
            default: begin
                clr_all = 1'b1;
            end
        endcase
    end

    // Registered outputs: operands, grant LED, failure count and lock flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cont_q   <= '0;
            led_q    <= 1'b0;
            locked_q <= 1'b0;
        end else if (clr_all) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cont_q   <= '0;
            led_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            if (load_ops) begin
                a_q   <= bus.ubInputData;
                b_q   <= bus.ubCredential;
                op_q  <= OP_SUB;
                led_q <= 1'b0;
            end
            if (set_grant) begin
                led_q  <= 1'b1;
                cont_q <= '0;
            end else if (inc_cont) begin
                cont_q <= sat_inc(cont_q, MAX_CNT);
            end else if (clr_cont) begin
                cont_q <= '0;
            end
            if (timer_load) begin
                locked_q <= 1'b1;
            end else if (lock_clr) begin
                locked_q <= 1'b0;
            end
        end
    end

    lock_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    assign bus.oA_T      = a_q;
    assign bus.oB_T      = b_q;
    assign bus.oOp_T     = op_q;
    assign bus.ubCont    = cont_q;
    assign bus.vfnLED_On = led_q;
    assign bus.oLocked   = locked_q;
    assign bus.oBusy     = busy;
    assign bus.oDone     = done;

endmodule

// File: tb/tb_credential_lock_ctrl.sv
// Self-checking bench for credential_lock_ctrl (default and minimal parameter sets).
// Latency: n/a.
// Backpressure: n/a.
module tb_credential_lock_ctrl;
    import credential_lock_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests  = 0;
    int errors = 0;

    credential_lock_ctrl_if #(.DATA_W(4)) u  ();
    credential_lock_ctrl_if #(.DATA_W(4)) u2 ();

    credential_lock_ctrl #(.DATA_W(4), .MAX_TRIES(3), .LOCK_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u)
    );

    credential_lock_ctrl #(.DATA_W(4), .MAX_TRIES(1), .LOCK_CYCLES(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (u2)
    );

    // ALU model with one cycle of registered latency: zero flag set when A-B is 0
    always @(posedge clk) begin
        u.status  <= {(u.oA_T - u.oB_T) == 4'd0, 4'($urandom)};
        u.R       <= u.oA_T - u.oB_T;
        u2.status <= {(u2.oA_T - u2.oB_T) == 4'd0, 4'($urandom)};
        u2.R      <= u2.oA_T - u2.oB_T;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // scoreboard of expected check results, popped when oDone fires
    typedef struct {
        logic led;
        int   cont;
        int   start;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (rst === 1'b1 && u.oDone === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL done_without_request: oDone=1 at cycle %0d, expected no completion", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_latency", cyc - e.start, 4);
                check("done_led", int'(u.vfnLED_On), int'(e.led));
                check("done_cont", int'(u.ubCont), e.cont);
            end
        end
    end

    // Called at a negedge in IDLE; returns at the negedge of the GRANT/FAIL cycle
    task automatic start_attempt(input logic [3:0] a, input logic [3:0] b,
                                 input logic led, input int cont);
        exp_t e;
        bit   seen;
        u.ubInputData  = a;
        u.ubCredential = b;
        u.iStart       = 1'b1;
        e.led   = led;
        e.cont  = cont;
        e.start = cyc;
        sb.push_back(e);
        @(negedge clk);
        u.iStart = 1'b0;
        check("issue_a", int'(u.oA_T), int'(a));
        check("issue_b", int'(u.oB_T), int'(b));
        check("issue_op", int'(u.oOp_T), 1);
        check("issue_led_clear", int'(u.vfnLED_On), 0);
        check("issue_busy", int'(u.oBusy), 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (u.oDone) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", int'(seen), 1);
    endtask

    // Called at the FAIL negedge; counts locked cycles while poking iStart, returns in IDLE
    task automatic measure_lock(input int exp_len);
        int n;
        n = 0;
        u.ubInputData  = 4'h5;
        u.ubCredential = 4'h5;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!u.oLocked) break;
            n++;
            u.iStart = i[0];
        end
        u.iStart = 1'b0;
        check("lock_len", n, exp_len);
        check("lock_end_cont", int'(u.ubCont), 0);
        check("lock_end_busy", int'(u.oBusy), 0);
        check("lock_end_led", int'(u.vfnLED_On), 0);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       led;
        int         cont;
        logic       lock;
    } vec_t;
    vec_t vecs[10];

    initial begin
        bit seen2;
        int start2;

        vecs[0] = '{4'h5, 4'h5, 1'b1, 0, 1'b0};
        vecs[1] = '{4'h3, 4'h5, 1'b0, 1, 1'b0};
        vecs[2] = '{4'h3, 4'h5, 1'b0, 2, 1'b0};
        vecs[3] = '{4'h5, 4'h5, 1'b1, 0, 1'b0};
        vecs[4] = '{4'hA, 4'hB, 1'b0, 1, 1'b0};
        vecs[5] = '{4'hF, 4'hF, 1'b1, 0, 1'b0};
        vecs[6] = '{4'h0, 4'h0, 1'b1, 0, 1'b0};
        vecs[7] = '{4'h9, 4'h1, 1'b0, 1, 1'b0};
        vecs[8] = '{4'h9, 4'h1, 1'b0, 2, 1'b0};
        vecs[9] = '{4'h9, 4'h1, 1'b0, 3, 1'b1};

        rst             = 1'b0;
        u.iStart        = 1'b0;
        u.ubInputData   = '0;
        u.ubCredential  = '0;
        u2.iStart       = 1'b0;
        u2.ubInputData  = '0;
        u2.ubCredential = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", int'(u.oBusy), 0);
        check("rst_locked", int'(u.oLocked), 0);
        check("rst_led", int'(u.vfnLED_On), 0);
        check("rst_cont", int'(u.ubCont), 0);
        check("rst_a", int'(u.oA_T), 0);
        check("rst_b", int'(u.oB_T), 0);
        check("rst_op", int'(u.oOp_T), 0);
        check("rst_done", int'(u.oDone), 0);

        // release and request in the same cycle: first edge must accept it
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start_attempt(vecs[i].a, vecs[i].b, vecs[i].led, vecs[i].cont);
            if (vecs[i].lock) begin
                measure_lock(16);
            end else begin
                @(negedge clk);
                check("idle_locked", int'(u.oLocked), 0);
                check("idle_busy", int'(u.oBusy), 0);
                check("idle_led_hold", int'(u.vfnLED_On), int'(vecs[i].led));
                check("idle_cont_hold", int'(u.ubCont), vecs[i].cont);
            end
        end

        // reset in the 7th cycle of a lockout
        start_attempt(4'h3, 4'h5, 1'b0, 1);
        @(negedge clk);
        start_attempt(4'h3, 4'h5, 1'b0, 2);
        @(negedge clk);
        start_attempt(4'h3, 4'h5, 1'b0, 3);
        repeat (7) @(negedge clk);
        check("midlock_locked", int'(u.oLocked), 1);
        rst = 1'b0;
        #1;
        check("midrst_locked", int'(u.oLocked), 0);
        check("midrst_cont", int'(u.ubCont), 0);
        check("midrst_busy", int'(u.oBusy), 0);
        @(negedge clk);
        rst = 1'b1;
        start_attempt(4'h5, 4'h5, 1'b1, 0);
        @(negedge clk);
        check("postrst_led", int'(u.vfnLED_On), 1);

        // MAX_TRIES=1, LOCK_CYCLES=1: one failure, one locked cycle
        u2.ubInputData  = 4'h3;
        u2.ubCredential = 4'h5;
        u2.iStart       = 1'b1;
        start2          = cyc;
        @(negedge clk);
        u2.iStart = 1'b0;
        seen2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (u2.oDone) begin
                seen2 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("m1_done_seen", int'(seen2), 1);
        check("m1_latency", cyc - start2, 4);
        check("m1_cont", int'(u2.ubCont), 1);
        check("m1_led", int'(u2.vfnLED_On), 0);
        @(negedge clk);
        check("m1_lock_on", int'(u2.oLocked), 1);
        check("m1_lock_busy", int'(u2.oBusy), 1);
        @(negedge clk);
        check("m1_lock_off", int'(u2.oLocked), 0);
        check("m1_idle_busy", int'(u2.oBusy), 0);
        check("m1_idle_cont", int'(u2.ubCont), 0);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/credential_lock_ctrl.md
CREDENTIAL_LOCK_CTRL -- requirements
Module: credential_lock_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DATA_W, 4, width of the entered data, credential, ALU operands and ALU result.
- MAX_TRIES, 3, number of consecutive failed attempts that triggers lockout; range 1..15.
- LOCK_CYCLES, 16, number of clock cycles the lockout lasts; must be at least 1.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, input, 1, single clock; all state changes on the rising edge.
- rst, input, 1, reset; asynchronous and active-low.
- iStart, input, 1, one-cycle request to check ubInputData; sampled only in IDLE.
- ubInputData, input, DATA_W, user-entered code.
- ubCredential, input, DATA_W, stored code.
- status, input, 5, ALU flags; status[4] is the zero flag.
- R, input, DATA_W, ALU result; not used for the decision.
- oA_T, output, DATA_W, ALU operand A.
- oB_T, output, DATA_W, ALU operand B.
- oOp_T, output, 4, ALU opcode.
- ubCont, output, 4, consecutive-failure count.
- vfnLED_On, output, 1, access granted.
- oLocked, output, 1, lockout active.
- oBusy, output, 1, check in progress.
- oDone, output, 1, one-cycle pulse marking the end of a check.

Function
REQ-003 The block SHALL implement the FSM states IDLE, ISSUE, WAIT, EVAL, GRANT, FAIL and LOCK.
REQ-004 IDLE with iStart=1 and oLocked=0 SHALL move to ISSUE on the next edge.
REQ-005 iStart SHALL be ignored in every state other than IDLE.
REQ-006 ISSUE SHALL register oA_T=ubInputData, oB_T=ubCredential and oOp_T=OP_SUB (4'd1), then go to WAIT.
REQ-007 WAIT SHALL last exactly one cycle to cover the ALU's registered latency, then go to EVAL.
REQ-008 EVAL SHALL sample status[4]: value 1 goes to GRANT, value 0 goes to FAIL.
REQ-009 GRANT SHALL set vfnLED_On=1, clear ubCont to 0, pulse oDone, then return to IDLE.
REQ-010 vfnLED_On SHALL stay 1 until the next accepted iStart, and SHALL clear in that ISSUE cycle.
REQ-011 FAIL SHALL increment ubCont with saturation at MAX_TRIES and pulse oDone.
- If the new count equals MAX_TRIES, go to LOCK.
- Otherwise return to IDLE.
REQ-012 LOCK SHALL set oLocked=1 and load the lock counter with LOCK_CYCLES-1.
- The counter decrements once per cycle.
- When the counter reaches 0: oLocked=0, ubCont=0, return to IDLE.
- Total oLocked high time is exactly LOCK_CYCLES cycles.
REQ-013 oBusy SHALL be 1 in ISSUE, WAIT, EVAL, GRANT, FAIL and LOCK, and 0 in IDLE.
REQ-014 Latency from iStart to oDone SHALL be exactly 4 cycles (ISSUE, WAIT, EVAL, GRANT/FAIL).
REQ-015 oA_T, oB_T and oOp_T SHALL hold their last values outside ISSUE.
REQ-016 Undefined FSM encodings SHALL recover to IDLE with all outputs at their reset values.
REQ-017 ubCont SHALL never exceed MAX_TRIES; the lock counter SHALL never wrap below 0.

Reset
REQ-018 rst=0 SHALL asynchronously force:
- FSM to IDLE;
- ubCont, the lock counter, oA_T, oB_T and oOp_T to 0;
- vfnLED_On, oLocked, oBusy and oDone to 0.
REQ-019 Reset asserted mid-check or mid-lockout SHALL abort the operation and discard the failure history.
REQ-020 After rst is released, the first iStart SHALL be accepted on the first rising edge.

Structure
REQ-021 A shared package SHALL hold:
- the ALU opcode constants (OP_ADD=4'd0, OP_SUB=4'd1, OP_INC=4'd13);
- the status bit index ZERO_BIT=4;
- the FSM state enumeration.
REQ-022 The lock countdown SHALL be a separate sub-module, lock_timer, parametrised by LOCK_CYCLES.
- Inputs: load, enable.
- Output: expired.

Verification
REQ-023 Defaults. Reset, then iStart with ubInputData=4'h5, ubCredential=4'h5, ALU model returning status[4]=1:
- oOp_T=1, oA_T=5, oB_T=5 in ISSUE;
- oDone 4 cycles after iStart;
- vfnLED_On=1 and ubCont=0.
REQ-024 Defaults. Two mismatching attempts (4'h3 vs 4'h5, status[4]=0) -> ubCont goes 1 then 2, oLocked stays 0, and vfnLED_On stays 0.
REQ-025 Defaults. Three mismatches ->
- oLocked rises in the cycle after the third FAIL and stays high exactly 16 cycles;
- iStart pulses during lockout are ignored;
- ubCont=0 after the lockout ends.
REQ-026 Defaults. Two failures followed by a match -> ubCont clears to 0 and vfnLED_On=1; a following iStart clears vfnLED_On in its ISSUE cycle.
REQ-027 rst pulsed low in mid-lockout (cycle 7 of 16) -> oLocked=0 and ubCont=0 immediately; the next matching iStart is granted.
REQ-028 MAX_TRIES=1, LOCK_CYCLES=1 -> a single mismatch gives exactly one oLocked cycle, then return to IDLE.
